divisao_sequencial: RTL and testbench
=====================================

// Module: divisao_sequencial
// PURPOSE
//  Multi-cycle sequencer for unsigned fixed-point division on Q(WIDTH-FRAC).FRAC operands
//  (default Q8.12, 20 bits).
//  - Computes quociente = (dividendo << FRAC) / divisor by restoring shift-subtract,
//    one quotient bit per clock.
//  - Uses a start/busy/done handshake, so the arithmetic unit can sit on a clocked bus
//    instead of a long combinational path.
// PARAMETERS
//  WIDTH  20  operand/result width in bits
//  FRAC   12  fractional bits in operands and result
// PORTS
//  clk         in   1      clock; all state changes on rising edge
//  rst         in   1      synchronous reset, active-high
//  inicio      in   1      start request; sampled only when ocupado=0
//  dividendo   in   WIDTH  dividend, Q format; captured on accepted start
//  divisor     in   WIDTH  divisor, Q format; captured on accepted start
//  quociente   out  WIDTH  registered result; held until the next result is written
//  ocupado     out  1      1 while state != IDLE
//  pronto      out  1      one-cycle pulse: result valid
//  erro        out  1      divide-by-zero flag for the last result
//  estouro     out  1      overflow flag for the last result
// BEHAVIOUR
//  - Reset: state=IDLE; quociente=0, ocupado=0, pronto=0, erro=0, estouro=0; counter=0.
//    Reset mid-operation aborts silently: no pronto pulse, partial result discarded.
//  - N = WIDTH+FRAC iterations (32 by default).
//  - FSM states IDLE, CALC, DONE:
//    - IDLE:
//      - inicio=1 at edge k: latch operands; numerator = {dividendo, FRAC'b0};
//        remainder=0; cnt=N.
//      - If divisor==0, go to DONE; otherwise go to CALC.
//      - inicio=0: stay in IDLE.
//    - CALC:
//      - Each edge: rem = {rem, num MSB}; num <<= 1.
//      - If rem >= divisor: rem -= divisor and shift in quotient bit 1; else shift in 0.
//      - Decrement cnt. The remainder register is WIDTH+1 bits wide.
//      - At the edge where cnt goes 1->0: write quociente/erro/estouro; go to DONE.
//    - DONE: pronto=1 for exactly one cycle; next edge goes to IDLE.
//  - Latency: normal case, pronto is high in the cycle after edge k+N. Divide-by-zero case,
//    pronto is high in the cycle after edge k+1.
//  - inicio while ocupado=1 (CALC or DONE) is ignored; there is no queueing. Operand changes
//    after acceptance have no effect.
//  - Overflow: the full quotient is N bits. If any of its upper FRAC bits is set:
//    quociente = all ones, estouro=1, erro=0.
//  - Divide by zero: quociente = all ones, erro=1, estouro=0.
//  - Otherwise: quociente = low WIDTH bits of the quotient, erro=0, estouro=0.
//  - erro/estouro stay valid with quociente until the next result write. They are not
//    cleared on accept.
// CONFIGURATION
//  DIV_ROUND_EN defined:
//  - Round to nearest. At the final iteration, if 2*final_rem >= divisor, add 1 to the
//    quotient.
//  - If the increment carries out of WIDTH bits, saturate to all ones and set estouro=1.
//  - Latency is unchanged.
//  DIV_ROUND_EN undefined: quotient is truncated toward zero.
// TESTING
//  1) dividendo=0x56000 (86.0), divisor=0x07000 (7.0), pulse inicio
//     -> pronto after N=32 edges; quociente=0x0C492; erro=0, estouro=0.
//  2) dividendo=0x02000 (2.0), divisor=0x03000 (3.0)
//     -> quociente=0x00AAA with truncation; 0x00AAB with DIV_ROUND_EN.
//  3) dividendo=0xFF000, divisor=0x00001 -> quociente=0xFFFFF, estouro=1, erro=0.
//  4) divisor=0x00000, any dividendo -> pronto in the cycle after edge k+1;
//     quociente=0xFFFFF, erro=1.
//  5) Start case 1; pulse inicio with new operands at cycle 5
//     -> ignored; result still 0x0C492; ocupado stays 1 until DONE->IDLE.
//  6) Start case 1; rst=1 at CALC cycle 10 -> all outputs 0 next edge, no pronto;
//     then start case 2 -> correct result.

Source files
------------

// File: rtl/divisao_sequencial.sv
// divisao_sequencial
//   Multi-cycle unsigned fixed-point divider for Q(WIDTH-FRAC).FRAC operands.
//   Computes quociente = (dividendo << FRAC) / divisor by restoring
//   shift-subtract, one quotient bit per clock, behind a start/busy/done
//   handshake.
//
//   Optional feature: define DIV_ROUND_EN to round to nearest instead of
//   truncating toward zero.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high; aborts any operation silently
//   inicio     start request, sampled only while ocupado=0
//   dividendo  dividend (Q format), captured on accepted start
//   divisor    divisor (Q format), captured on accepted start
//   quociente  registered result, held until the next result write
//   ocupado    high while the FSM is not idle
//   pronto     one-cycle pulse, result valid
//   erro       divide-by-zero flag for the last result
//   estouro    overflow flag for the last result
module divisao_sequencial #(
  parameter int WIDTH = 20,
  parameter int FRAC  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quociente,
  output logic             ocupado,
  output logic             pronto,
  output logic             erro,
  output logic             estouro
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT   = CW'(N);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [N-1:0]     num_r;
  logic [N-1:0]     quo_r;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] div_r;

  logic [WIDTH+1:0] rem_shift_s;
  logic [WIDTH:0]   rem_next_s;
  logic             ge_s;
  logic [N-1:0]     quo_next_s;
  logic             ovf_s;
  logic             rnd_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_s;
  logic             res_ovf_s;

  // One restoring iteration plus final result formatting (saturation/rounding)
  always_comb begin
    rem_shift_s = {rem_r, num_r[N-1]};
    // Stored remainder is always below the divisor, so the top bit only
    // guarantees the compare; the difference always fits WIDTH+1 bits.
    ge_s = rem_shift_s[WIDTH+1] | (rem_shift_s[WIDTH:0] >= {1'b0, div_r});
    if (ge_s) begin
      rem_next_s = rem_shift_s[WIDTH:0] - {1'b0, div_r};
    end else begin
      rem_next_s = rem_shift_s[WIDTH:0];
    end
    quo_next_s = {quo_r[N-2:0], ge_s};
    // Any set bit above WIDTH means the result does not fit the Q format
    ovf_s = |quo_next_s[N-1:WIDTH];
`ifdef DIV_ROUND_EN
    rnd_s = ({rem_next_s, 1'b0} >= {2'b00, div_r});
`else
    rnd_s = 1'b0;
`endif
    sum_s = {1'b0, quo_next_s[WIDTH-1:0]} + {{WIDTH{1'b0}}, rnd_s};
    if (ovf_s || sum_s[WIDTH]) begin
      res_s     = {WIDTH{1'b1}};
      res_ovf_s = 1'b1;
    end else begin
      res_s     = sum_s[WIDTH-1:0];
      res_ovf_s = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      num_r     <= {N{1'b0}};
      quo_r     <= {N{1'b0}};
      rem_r     <= {(WIDTH+1){1'b0}};
      div_r     <= {WIDTH{1'b0}};
      quociente <= {WIDTH{1'b0}};
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
      estouro   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pronto <= 1'b0;
          if (inicio) begin
            num_r   <= {dividendo, {FRAC{1'b0}}};
            div_r   <= divisor;
            rem_r   <= {(WIDTH+1){1'b0}};
            quo_r   <= {N{1'b0}};
            cnt_r   <= N_CNT;
            ocupado <= 1'b1;
            if (divisor == {WIDTH{1'b0}}) begin
              state_r <= DONE;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          num_r <= {num_r[N-2:0], 1'b0};
          quo_r <= quo_next_s;
          cnt_r <= cnt_r - ONE_CNT;
          if (cnt_r == ONE_CNT) begin
            quociente <= res_s;
            estouro   <= res_ovf_s;
            erro      <= 1'b0;
            pronto    <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          // Arriving from CALC the pulse is already up; arriving straight
          // from a zero-divisor accept the result is written here first.
          if (pronto) begin
            pronto  <= 1'b0;
            ocupado <= 1'b0;
            state_r <= IDLE;
          end else begin
            quociente <= {WIDTH{1'b1}};
            erro      <= 1'b1;
            estouro   <= 1'b0;
            pronto    <= 1'b1;
            state_r   <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          ocupado <= 1'b0;
          pronto  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisao_sequencial.sv
module tb_divisao_sequencial;

  localparam int W = 20;
  localparam int F = 12;
  localparam int N = W + F;

  typedef struct packed {
    logic [W-1:0] q;
    logic         e;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         inicio;
  logic [W-1:0] dividendo;
  logic [W-1:0] divisor;
  logic [W-1:0] quociente;
  logic         ocupado;
  logic         pronto;
  logic         erro;
  logic         estouro;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  divisao_sequencial #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .dividendo(dividendo),
    .divisor(divisor), .quociente(quociente), .ocupado(ocupado),
    .pronto(pronto), .erro(erro), .estouro(estouro)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: wide integer division of the scaled numerator
  function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
    logic [63:0] num, q, r;
    exp_t res;
    if (dv == '0) begin
      res = '{q: {W{1'b1}}, e: 1'b1, o: 1'b0};
      return res;
    end
    num = {32'd0, dd, 12'h000};
    q = num / {44'd0, dv};
    r = num % {44'd0, dv};
    if (q >= 64'h100000) begin
      res = '{q: {W{1'b1}}, e: 1'b0, o: 1'b1};
      return res;
    end
`ifdef DIV_ROUND_EN
    if ((r << 1) >= {44'd0, dv}) q = q + 64'd1;
    if (q >= 64'h100000) begin
      res = '{q: {W{1'b1}}, e: 1'b0, o: 1'b1};
      return res;
    end
`endif
    res = '{q: q[W-1:0], e: 1'b0, o: 1'b0};
    return res;
  endfunction

  // Pulse inicio for one cycle; returns at the negedge after the accept edge
  task automatic start(input logic [W-1:0] dd, input logic [W-1:0] dv);
    @(negedge clk);
    dividendo = dd;
    divisor   = dv;
    inicio    = 1'b1;
    @(negedge clk);
    inicio    = 1'b0;
  endtask

  // Wait (bounded) for pronto, check latency and pop/compare the scoreboard
  task automatic wait_result(input string tag, input int lat, input int c0);
    int   c;
    exp_t e;
    c = c0;
    while (!pronto && c < N + 10) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_pronto"}, 32'(pronto), 32'd1);
    if (pronto) begin
      check({tag, "_latency"}, 32'(c), 32'(lat));
      check({tag, "_ocupado"}, 32'(ocupado), 32'd1);
      if (sb.size() == 0) begin
        check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check({tag, "_quociente"}, 32'(quociente), 32'(e.q));
        check({tag, "_erro"}, 32'(erro), 32'(e.e));
        check({tag, "_estouro"}, 32'(estouro), 32'(e.o));
      end
      @(negedge clk);
      check({tag, "_pulse_end"}, 32'(pronto), 32'd0);
      check({tag, "_idle"}, 32'(ocupado), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    logic [W-1:0] rd, rv;
    rst = 1'b1;
    inicio = 1'b0;
    dividendo = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_quociente", 32'(quociente), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    check("rst_estouro", 32'(estouro), 32'd0);
    rst = 1'b0;

    // 1) 86.0 / 7.0
    sb.push_back('{q: 20'h0C492, e: 1'b0, o: 1'b0});
    start(20'h56000, 20'h07000);
    check("t1_busy", 32'(ocupado), 32'd1);
    wait_result("t1", N, 0);

    // 2) 2.0 / 3.0
`ifdef DIV_ROUND_EN
    sb.push_back('{q: 20'h00AAB, e: 1'b0, o: 1'b0});
`else
    sb.push_back('{q: 20'h00AAA, e: 1'b0, o: 1'b0});
`endif
    start(20'h02000, 20'h03000);
    wait_result("t2", N, 0);

    // 3) overflow
    sb.push_back('{q: 20'hFFFFF, e: 1'b0, o: 1'b1});
    start(20'hFF000, 20'h00001);
    wait_result("t3", N, 0);

    // 4) divide by zero
    sb.push_back('{q: 20'hFFFFF, e: 1'b1, o: 1'b0});
    start(20'h12345, 20'h00000);
    wait_result("t4", 1, 0);

    // 5) start ignored while busy
    sb.push_back('{q: 20'h0C492, e: 1'b0, o: 1'b0});
    start(20'h56000, 20'h07000);
    repeat (3) @(negedge clk);
    dividendo = 20'h12345;
    divisor   = 20'h00100;
    inicio    = 1'b1;
    @(negedge clk);
    inicio    = 1'b0;
    check("t5_busy", 32'(ocupado), 32'd1);
    wait_result("t5", N, 4);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pronto || ocupado) seen++;
    end
    check("t5_no_queue", 32'(seen), 32'd0);

    // 6) reset mid-calculation aborts silently
    start(20'h56000, 20'h07000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_quociente", 32'(quociente), 32'd0);
    check("t6_ocupado", 32'(ocupado), 32'd0);
    check("t6_pronto", 32'(pronto), 32'd0);
    check("t6_erro", 32'(erro), 32'd0);
    check("t6_estouro", 32'(estouro), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < N + 5; i++) begin
      @(negedge clk);
      if (pronto) seen++;
    end
    check("t6_no_pronto", 32'(seen), 32'd0);
`ifdef DIV_ROUND_EN
    sb.push_back('{q: 20'h00AAB, e: 1'b0, o: 1'b0});
`else
    sb.push_back('{q: 20'h00AAA, e: 1'b0, o: 1'b0});
`endif
    start(20'h02000, 20'h03000);
    wait_result("t6_after", N, 0);

    // Assorted operands checked against the reference model
    for (int i = 0; i < 6; i++) begin
      rd = W'($urandom_range(0, 32'hFFFFF));
      if (i < 3) rv = W'($urandom_range(32'h01000, 32'hFFFFF));
      else       rv = W'($urandom_range(1, 32'h00FFF));
      sb.push_back(model(rd, rv));
      start(rd, rv);
      wait_result("rand", N, 0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
